// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - shared CPU/PPU bus map constants and OAM DMA state encoding
package nes_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
  localparam int          OAM_XFER_LEN  = 256;

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// rtl/oam_dma_ctrl_if.sv - CPU-side and memory-side bus signals around the OAM DMA arbiter
interface oam_dma_ctrl_if;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ren;
  logic        cpu_wen;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ren;
  logic        bus_wen;
  logic [7:0]  bus_rdata;
  logic        dma_active;

  // master: the arbiter itself, owning the memory bus and the CPU ready line
  modport master (
    input  cpu_addr, cpu_wdata, cpu_ren, cpu_wen, bus_rdata,
    output cpu_rdy, bus_addr, bus_wdata, bus_ren, bus_wen, dma_active
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_ren, cpu_wen, bus_rdata,
    input  cpu_rdy, bus_addr, bus_wdata, bus_ren, bus_wen, dma_active
  );

endinterface

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - sprite DMA engine: halts the CPU and copies one page to the OAM data port
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = nes_bus_pkg::DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = nes_bus_pkg::OAM_DATA_ADDR,
  parameter int          XFER_LEN      = nes_bus_pkg::OAM_XFER_LEN
) (
  input  logic                  clk,
  input  logic                  b_rst,
  oam_dma_ctrl_if.master        bus_if
);

  localparam int               IDX_W    = $clog2(XFER_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XFER_LEN - 1);

  dma_state_t        state_q, state_d;
  logic [7:0]        page_q, page_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        dbuf_q, dbuf_d;
  logic              cyc_odd_q, cyc_odd_d;

  logic              dma_active;
  logic [15:0]       dma_addr;
  logic [7:0]        dma_wdata;
  logic              dma_ren;
  logic              dma_wen;
  logic [15:0]       src_addr;

  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      state_q   <= IDLE;
      page_q    <= '0;
      idx_q     <= '0;
      dbuf_q    <= '0;
      cyc_odd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      idx_q     <= idx_d;
      dbuf_q    <= dbuf_d;
      cyc_odd_q <= cyc_odd_d;
    end
  end

  // Page and index join without carry, so the source never leaves the page.
  assign src_addr = {page_q, 8'h00} | 16'(idx_q);

  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    idx_d     = idx_q;
    dbuf_d    = dbuf_q;
    cyc_odd_d = ~cyc_odd_q;
    case (state_q)
      IDLE: begin
        if (bus_if.cpu_wen && (bus_if.cpu_addr == DMA_REG_ADDR)) begin
          page_d  = bus_if.cpu_wdata;
          idx_d   = '0;
          state_d = HALT;
        end
      end
      HALT: begin
        state_d = cyc_odd_q ? ALIGN : READ;
      end
      ALIGN: begin
        state_d = READ;
      end
      READ: begin
        dbuf_d  = bus_if.bus_rdata;
        state_d = WRITE;
      end
      WRITE: begin
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = READ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // DMA-side bus drive; HALT and ALIGN are dead cycles that keep the CPU address.
  always_comb begin
    dma_addr  = bus_if.cpu_addr;
    dma_wdata = bus_if.cpu_wdata;
    dma_ren   = 1'b0;
    dma_wen   = 1'b0;
    case (state_q)
      READ: begin
        dma_addr = src_addr;
        dma_ren  = 1'b1;
      end
      WRITE: begin
        dma_addr  = OAM_DATA_ADDR;
        dma_wdata = dbuf_q;
        dma_wen   = 1'b1;
      end
      default: begin
        dma_addr = bus_if.cpu_addr;
      end
    endcase
  end

  assign dma_active = (state_q != IDLE);

  always_comb begin
    bus_if.dma_active = dma_active;
    bus_if.cpu_rdy    = ~dma_active;
    if (dma_active) begin
      bus_if.bus_addr  = dma_addr;
      bus_if.bus_wdata = dma_wdata;
      bus_if.bus_ren   = dma_ren;
      bus_if.bus_wen   = dma_wen;
    end else begin
      bus_if.bus_addr  = bus_if.cpu_addr;
      bus_if.bus_wdata = bus_if.cpu_wdata;
      bus_if.bus_ren   = bus_if.cpu_ren;
      bus_if.bus_wen   = bus_if.cpu_wen;
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - scoreboard bench for the OAM DMA controller
module tb_oam_dma_ctrl;

  logic clk;
  logic b_rst;

  oam_dma_ctrl_if dif ();

  oam_dma_ctrl dut (
    .clk    (clk),
    .b_rst  (b_rst),
    .bus_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] rd_q[$];
  logic [7:0]  wr_q[$];
  int          exp_stall = 0;
  int          stall_cnt = 0;
  int          done_cnt  = 0;
  int          wr_seen   = 0;
  int          edge_cnt;

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    if (a[15:8] == 8'h02) return a[7:0] ^ 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  assign dif.bus_rdata = mem_val(dif.bus_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk or negedge b_rst) begin
    if (!b_rst) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  always @(negedge clk) begin
    logic [15:0] ea;
    logic [7:0]  ed;
    if (!b_rst) begin
      stall_cnt = 0;
    end else if (!dif.dma_active) begin
      chk("rdy_idle", {31'd0, dif.cpu_rdy}, 1);
      chk("passthru", {dif.bus_addr, dif.bus_wdata, dif.bus_ren, dif.bus_wen},
          {dif.cpu_addr, dif.cpu_wdata, dif.cpu_ren, dif.cpu_wen});
      if (stall_cnt != 0) begin
        chk("stall_len", stall_cnt, exp_stall);
        stall_cnt = 0;
        done_cnt++;
      end
    end else begin
      stall_cnt++;
      chk("rdy_busy", {31'd0, dif.cpu_rdy}, 0);
      if (dif.bus_ren) begin
        chk("rd_no_wen", {31'd0, dif.bus_wen}, 0);
        if (rd_q.size() == 0) chk("rd_unexp", 1, 0);
        else begin
          ea = rd_q.pop_front();
          chk("rd_addr", {16'd0, dif.bus_addr}, {16'd0, ea});
        end
      end else if (dif.bus_wen) begin
        wr_seen++;
        if (wr_q.size() == 0) chk("wr_unexp", 1, 0);
        else begin
          ed = wr_q.pop_front();
          chk("wr_addr", {16'd0, dif.bus_addr}, 32'h2004);
          chk("wr_data", {24'd0, dif.bus_wdata}, {24'd0, ed});
        end
      end else begin
        chk("dummy_addr", {16'd0, dif.bus_addr}, {16'd0, dif.cpu_addr});
      end
    end
  end

  task automatic cpu_idle();
    dif.cpu_addr  = 16'hC123;
    dif.cpu_wdata = 8'h99;
    dif.cpu_ren   = 1'b0;
    dif.cpu_wen   = 1'b0;
  endtask

  task automatic trigger(input logic [7:0] pg, input int odd, input bit hold, output int snap);
    @(posedge clk); #1;
    while (((edge_cnt + 1) & 1) != odd) begin
      @(posedge clk); #1;
    end
    dif.cpu_addr  = 16'h4014;
    dif.cpu_wdata = pg;
    dif.cpu_wen   = 1'b1;
    dif.cpu_ren   = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rd_q.push_back({pg, 8'(i)});
      wr_q.push_back(mem_val({pg, 8'(i)}));
    end
    exp_stall = 513 + odd;
    snap = done_cnt;
    @(posedge clk); #1;
    chk("rdy_fall", {31'd0, dif.cpu_rdy}, 0);
    chk("act_rise", {31'd0, dif.dma_active}, 1);
    if (hold) dif.cpu_wdata = 8'h07;
    else      cpu_idle();
  endtask

  task automatic wait_done(input int snap, input bit hold);
    int cyc;
    cyc = 0;
    while (done_cnt == snap && cyc < 1200) begin
      @(posedge clk); #1;
      if (hold && dif.cpu_rdy) cpu_idle();
      cyc++;
    end
    if (done_cnt == snap) chk("xfer_timeout", 0, 1);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
  endtask

  initial begin
    int snap;
    int w0;
    int cyc;
    b_rst = 1'b0;
    dif.cpu_addr  = 16'h1234;
    dif.cpu_wdata = 8'h55;
    dif.cpu_ren   = 1'b1;
    dif.cpu_wen   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", {31'd0, dif.cpu_rdy}, 1);
    chk("rst_act", {31'd0, dif.dma_active}, 0);
    chk("rst_pass", {dif.bus_addr, dif.bus_wdata, dif.bus_ren, dif.bus_wen}, {16'h1234, 8'h55, 1'b1, 1'b0});
    @(negedge clk);
    b_rst = 1'b1;

    // IDLE passthrough of an ordinary read and write
    @(posedge clk); #1;
    dif.cpu_addr = 16'h8000; dif.cpu_ren = 1'b1; dif.cpu_wen = 1'b0;
    @(posedge clk); #1;
    dif.cpu_addr = 16'h2001; dif.cpu_wdata = 8'h1E; dif.cpu_ren = 1'b0; dif.cpu_wen = 1'b1;
    @(posedge clk); #1;
    cpu_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("pass_no_dma", {31'd0, dif.dma_active}, 0);

    trigger(8'h02, 0, 1'b0, snap);
    wait_done(snap, 1'b0);

    trigger(8'h02, 1, 1'b0, snap);
    wait_done(snap, 1'b0);

    // CPU keeps writing $4014 through the stall
    trigger(8'h02, 0, 1'b1, snap);
    wait_done(snap, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("no_retrig", {31'd0, dif.dma_active}, 0);

    // Reset after 100 OAM writes
    w0 = wr_seen;
    trigger(8'h02, 0, 1'b0, snap);
    cyc = 0;
    while (wr_seen < w0 + 100 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid_wr_cnt", wr_seen - w0, 100);
    b_rst = 1'b0;
    #1;
    chk("mid_rst_rdy", {31'd0, dif.cpu_rdy}, 1);
    chk("mid_rst_act", {31'd0, dif.dma_active}, 0);
    chk("mid_rst_pass", {dif.bus_addr, dif.bus_wdata, dif.bus_ren, dif.bus_wen}, {16'hC123, 8'h99, 1'b0, 1'b0});
    rd_q.delete();
    wr_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    b_rst = 1'b1;
    trigger(8'h03, 1, 1'b0, snap);
    wait_done(snap, 1'b0);

    trigger(8'hFF, 0, 1'b0, snap);
    wait_done(snap, 1'b0);
    chk("ff_idle", {31'd0, dif.dma_active}, 0);

    trigger(8'h00, 1, 1'b0, snap);
    wait_done(snap, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
Sprite (OAM) DMA controller and CPU bus arbiter. It sits between the 6502 core's bus outputs and the memory/PPU bus. In IDLE it passes CPU cycles through unchanged. When the CPU writes to the DMA register, it halts the CPU via cpu_rdy, takes ownership of the bus and copies 256 bytes from page {D,8'h00} to the OAM data port.

Parameters:
DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA.
OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.
XFER_LEN, 256, bytes per transfer. Index counter is $clog2(XFER_LEN) bits wide.

Ports:
clk  in  1  system clock, all state on rising edge
b_rst  in  1  asynchronous, active-low reset
cpu_addr  in  16  CPU address output
cpu_wdata  in  8  CPU write data
cpu_ren  in  1  CPU read strobe
cpu_wen  in  1  CPU write strobe
cpu_rdy  out  1  ready to CPU; low halts CPU, and CPU strobes are ignored while low
bus_addr  out  16  arbitrated bus address
bus_wdata  out  8  arbitrated write data
bus_ren  out  1  arbitrated read strobe
bus_wen  out  1  arbitrated write strobe
bus_rdata  in  8  read data; combinationally valid in the same cycle as bus_ren
dma_active  out  1  high in every non-IDLE state

Behaviour:
- Reset values (asynchronous, while b_rst=0): state=IDLE, page=0, idx=0, dbuf=0, cyc_odd=0, cpu_rdy=1, dma_active=0. Bus outputs equal the CPU passthrough.
- cyc_odd toggles every clk from reset release. It is free-running and independent of state.
- States:
  - IDLE
    - bus_* = cpu_*, cpu_rdy=1.
    - If cpu_wen=1 and cpu_addr==DMA_REG_ADDR: page<=cpu_wdata, idx<=0, next state HALT.
    - The trigger write itself still passes to the bus unchanged.
  - HALT (1 dummy cycle)
    - cpu_rdy=0, bus_ren=bus_wen=0, bus_addr=cpu_addr.
    - Next state ALIGN if cyc_odd==1, else READ.
  - ALIGN (1 dummy cycle, same outputs as HALT)
    - Next state READ.
  - READ
    - bus_addr={page,idx}, bus_ren=1, bus_wen=0.
    - dbuf<=bus_rdata at end of cycle.
    - Next state WRITE.
  - WRITE
    - bus_addr=OAM_DATA_ADDR, bus_wen=1, bus_wdata=dbuf, bus_ren=0.
    - If idx==XFER_LEN-1: next state IDLE, idx<=0. Else idx<=idx+1, next state READ.
- cpu_rdy = (state==IDLE) and dma_active = (state!=IDLE). Both are decoded from the state register only, never from inputs.
- Latency:
  - cpu_rdy falls in the cycle after the trigger write.
  - Stall length is 513 cycles (cyc_odd=0 in HALT) or 514 cycles (cyc_odd=1 in HALT).
  - cpu_rdy is high again in the cycle after the last WRITE.
- Address width: idx and page concatenate without carry. Source addresses never cross out of the page; the last read is {page,8'hFF}.
- Page values that overlap I/O (e.g. 8'h20, 8'h40) are read like any other page, with no special case.
- A CPU write to DMA_REG_ADDR while not in IDLE is ignored, because CPU strobes are masked while cpu_rdy=0.
- Reset mid-transfer: returns immediately to IDLE and cpu_rdy=1. The partial transfer is abandoned and is not resumed.
- A trigger write whose data is 8'h00 is legal and transfers page 0.

Decomposition:
- Package nes_bus_pkg holds:
  - typedef enum logic [2:0] dma_state_t {IDLE, HALT, ALIGN, READ, WRITE}
  - localparams DMA_REG_ADDR, OAM_DATA_ADDR and OAM_XFER_LEN, shared with the PPU and memory-map decode.
- Single module with no sub-module. Arbitration is a 2:1 mux selected by dma_active and is kept inline.

Test Plan:
- Trigger on even cycle (cyc_odd=0 in HALT), data 8'h02, memory $0200+i = i ^ 8'h5A → 256 writes to $2004 with values i^8'h5A in order. cpu_rdy low for exactly 513 cycles.
- Same trigger aligned so cyc_odd=1 in HALT → one ALIGN cycle with no strobes. cpu_rdy low for exactly 514 cycles.
- CPU holds cpu_wen=1 to $4014 with data 8'h07 throughout the stall → transfer uses page 8'h02, bus never shows the CPU write, no retrigger after return to IDLE.
- Assert b_rst low after 100 WRITE cycles → same cycle: cpu_rdy=1, dma_active=0, bus mirrors CPU. A new trigger with page 8'h03 then runs a full 256-byte transfer starting at $0300.
- IDLE passthrough: CPU read $8000 and CPU write $2001=8'h1E → bus_* exactly equal cpu_*, cpu_rdy stays 1, no state change.
- Page 8'hFF → last read address $FFFF, then IDLE. No wrap into page 0, and idx returns to 0.
